// File: rtl/vga_pkg.sv
// Shared VGA timing presets and the sync-window predicate used by the
// vga_timing_gen axis counters.
package vga_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  // 800x600@60 (40 MHz pixel clock), positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;

  function automatic logic in_sync_window(input int unsigned pos,
                                          input int unsigned start,
                                          input int unsigned width);
    return (pos >= start) && (pos < start + width);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: wrapping position counter plus active-area and sync-level
// decode for that axis.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FRONT  = VGA640_H_FRONT,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BACK   = VGA640_H_BACK,
  parameter bit POL    = 1'b0,
  parameter int W      = $clog2(ACTIVE + FRONT + SYNC + BACK)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_active,
  output logic         sync_level
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);

  generate
    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
      $error("vga_axis_counter: every timing term must be >= 1");
    end
  endgenerate

  assign wrap = step && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

  assign in_active  = (count < ACTIVE_END);
  assign sync_level = in_sync_window(32'(count), 32'(ACTIVE + FRONT), 32'(SYNC)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: pixel divider, h/v counters, registered
// blanked colour and sync outputs, and GPIO output-enable control.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FRONT  = VGA640_H_FRONT,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BACK   = VGA640_H_BACK,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FRONT  = VGA640_V_FRONT,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BACK   = VGA640_V_BACK,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL,
  parameter int RGB_W    = 3,
  parameter int CLK_DIV  = 1,
  parameter int FRAME_W  = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               pix_en,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   rgb,
  output logic               display_on,
  output logic               oeb_hs,
  output logic               oeb_vs,
  output logic [RGB_W-1:0]   oeb_rgb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (RGB_W < 1 || RGB_W > 24) begin : g_bad_rgb
      $error("vga_timing_gen: RGB_W must be within 1..24");
    end
    if (FRAME_W < 1) begin : g_bad_frame
      $error("vga_timing_gen: FRAME_W must be >= 1");
    end
  endgenerate

  logic [DW-1:0] div_reg;
  logic          run_reg;
  logic          clr;
  logic          h_wrap, v_wrap;
  logic          h_active, v_active, active;
  logic          h_sync, v_sync;

  assign clr = ~enable;

  // run_reg marks the first enabled clk; the divider only starts counting after it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg <= 1'b0;
      div_reg <= '0;
    end else if (clr) begin
      run_reg <= 1'b0;
      div_reg <= '0;
    end else begin
      run_reg <= 1'b1;
      if (run_reg) begin
        div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
      end
    end
  end

  assign pix_en = run_reg && (div_reg == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (HS_POL),
    .W      (XW)
  ) u_h_axis (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .step       (pix_en),
    .count      (x),
    .wrap       (h_wrap),
    .in_active  (h_active),
    .sync_level (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (VS_POL),
    .W      (YW)
  ) u_v_axis (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .step       (h_wrap),
    .count      (y),
    .wrap       (v_wrap),
    .in_active  (v_active),
    .sync_level (v_sync)
  );

  assign active      = h_active && v_active;
  assign line_start  = pix_en && (x == '0);
  assign frame_start = line_start && (y == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (enable && v_wrap) begin
      frame_count <= frame_count + FRAME_W'(1);
    end
  end

  // Pipeline stage: decoded from the pre-increment x/y of the current pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      rgb        <= '0;
      display_on <= 1'b0;
    end else if (clr) begin
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      rgb        <= '0;
      display_on <= 1'b0;
    end else if (pix_en) begin
      hsync      <= h_sync;
      vsync      <= v_sync;
      rgb        <= active ? rgb_in : '0;
      display_on <= active;
    end
  end

  assign oeb_hs = ~run_reg;
  assign oeb_vs = ~run_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RGB_W; gi++) begin : g_oeb_rgb
      assign oeb_rgb[gi] = ~run_reg;
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench for vga_timing_gen: three parameter sets
// compared every clk against an arithmetic pixel-index model.
module tb_vga_timing_gen;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  always #5 clk = ~clk;

  // d0: small timing, CLK_DIV=1, active-low syncs, 2-bit frame counter
  logic [2:0] d0_rgb_in, d0_rgb, d0_oeb_rgb;
  logic [3:0] d0_x;
  logic [2:0] d0_y;
  logic [1:0] d0_frame_count;
  logic d0_pix_en, d0_line_start, d0_frame_start, d0_hsync, d0_vsync, d0_display_on, d0_oeb_hs, d0_oeb_vs;

  // d1: small timing, CLK_DIV=3, active-high syncs, 5-bit colour
  logic [4:0] d1_rgb_in, d1_rgb, d1_oeb_rgb;
  logic [3:0] d1_x;
  logic [2:0] d1_y;
  logic [7:0] d1_frame_count;
  logic d1_pix_en, d1_line_start, d1_frame_start, d1_hsync, d1_vsync, d1_display_on, d1_oeb_hs, d1_oeb_vs;

  // d2: default 640x480
  logic [2:0] d2_rgb_in, d2_rgb, d2_oeb_rgb;
  logic [9:0] d2_x;
  logic [9:0] d2_y;
  logic [7:0] d2_frame_count;
  logic d2_pix_en, d2_line_start, d2_frame_start, d2_hsync, d2_vsync, d2_display_on, d2_oeb_hs, d2_oeb_vs;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RGB_W(3), .CLK_DIV(1), .FRAME_W(2)
  ) u_d0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rgb_in(d0_rgb_in),
    .x(d0_x), .y(d0_y), .pix_en(d0_pix_en), .line_start(d0_line_start),
    .frame_start(d0_frame_start), .frame_count(d0_frame_count),
    .hsync(d0_hsync), .vsync(d0_vsync), .rgb(d0_rgb), .display_on(d0_display_on),
    .oeb_hs(d0_oeb_hs), .oeb_vs(d0_oeb_vs), .oeb_rgb(d0_oeb_rgb)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RGB_W(5), .CLK_DIV(3), .FRAME_W(8)
  ) u_d1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rgb_in(d1_rgb_in),
    .x(d1_x), .y(d1_y), .pix_en(d1_pix_en), .line_start(d1_line_start),
    .frame_start(d1_frame_start), .frame_count(d1_frame_count),
    .hsync(d1_hsync), .vsync(d1_vsync), .rgb(d1_rgb), .display_on(d1_display_on),
    .oeb_hs(d1_oeb_hs), .oeb_vs(d1_oeb_vs), .oeb_rgb(d1_oeb_rgb)
  );

  vga_timing_gen u_d2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rgb_in(d2_rgb_in),
    .x(d2_x), .y(d2_y), .pix_en(d2_pix_en), .line_start(d2_line_start),
    .frame_start(d2_frame_start), .frame_count(d2_frame_count),
    .hsync(d2_hsync), .vsync(d2_vsync), .rgb(d2_rgb), .display_on(d2_display_on),
    .oeb_hs(d2_oeb_hs), .oeb_vs(d2_oeb_vs), .oeb_rgb(d2_oeb_rgb)
  );

  // Model parameters per instance
  int ht[ND]          = '{15, 15, 800};
  int vt[ND]          = '{8, 8, 525};
  int ha[ND]          = '{8, 8, 640};
  int va[ND]          = '{4, 4, 480};
  int hsync_start[ND] = '{10, 10, 656};
  int hsync_len[ND]   = '{3, 3, 96};
  int vsync_start[ND] = '{5, 5, 490};
  int vsync_len[ND]   = '{2, 2, 2};
  int hp[ND]          = '{0, 1, 0};
  int vp[ND]          = '{0, 1, 0};
  int dv[ND]          = '{1, 3, 1};
  int fw[ND]          = '{2, 8, 8};
  int rgbw[ND]        = '{3, 5, 3};

  // Model state: running flag, clks since first enabled clk, frame base, last captured colour
  bit run[ND];
  int t[ND];
  int fcb[ND];
  int cap[ND];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit measure = 1'b0;

  int rl_len[4];
  int pd_last[4];
  int fs0_first = -1;
  logic d0_hs_prev, d2_hs_prev;
  logic [3:0] d0_x_prev;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int cur_fc(input int k);
    if (!run[k]) return fcb[k];
    return (fcb[k] + (t[k] / dv[k]) / (ht[k] * vt[k])) % (1 << fw[k]);
  endfunction

  function automatic bit pix_exp(input int k);
    return run[k] && ((t[k] % dv[k]) == dv[k] - 1);
  endfunction

  function automatic logic [63:0] exp_pack(input int k);
    int n, x, y, p, px, py, hs, vs, rgb, don, pix, off;
    hs = 1 - hp[k]; vs = 1 - vp[k]; rgb = 0; don = 0; x = 0; y = 0; pix = 0;
    if (run[k]) begin
      n = t[k] / dv[k];
      x = n % ht[k];
      y = (n / ht[k]) % vt[k];
      pix = pix_exp(k) ? 1 : 0;
      if (n > 0) begin
        p = n - 1;
        px = p % ht[k];
        py = (p / ht[k]) % vt[k];
        if (px >= hsync_start[k] && px < hsync_start[k] + hsync_len[k]) hs = hp[k];
        if (py >= vsync_start[k] && py < vsync_start[k] + vsync_len[k]) vs = vp[k];
        if (px < ha[k] && py < va[k]) begin
          don = 1;
          rgb = cap[k];
        end
      end
    end
    off = run[k] ? 0 : 1;
    return {16'(x), 16'(y), 8'(cur_fc(k)), 8'(rgb), 8'(off != 0 ? (1 << rgbw[k]) - 1 : 0),
            1'(pix), 1'(pix != 0 && x == 0), 1'(pix != 0 && x == 0 && y == 0),
            1'(hs), 1'(vs), 1'(don), 1'(off), 1'(off)};
  endfunction

  function automatic logic [63:0] obs(input int k);
    case (k)
      0: return {16'(d0_x), 16'(d0_y), 8'(d0_frame_count), 8'(d0_rgb), 8'(d0_oeb_rgb),
                 d0_pix_en, d0_line_start, d0_frame_start, d0_hsync, d0_vsync, d0_display_on, d0_oeb_hs, d0_oeb_vs};
      1: return {16'(d1_x), 16'(d1_y), 8'(d1_frame_count), 8'(d1_rgb), 8'(d1_oeb_rgb),
                 d1_pix_en, d1_line_start, d1_frame_start, d1_hsync, d1_vsync, d1_display_on, d1_oeb_hs, d1_oeb_vs};
      default: return {16'(d2_x), 16'(d2_y), 8'(d2_frame_count), 8'(d2_rgb), 8'(d2_oeb_rgb),
                 d2_pix_en, d2_line_start, d2_frame_start, d2_hsync, d2_vsync, d2_display_on, d2_oeb_hs, d2_oeb_vs};
    endcase
  endfunction

  task automatic model_reset_all();
    for (int k = 0; k < ND; k++) begin
      run[k] = 1'b0;
      t[k] = 0;
      fcb[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    if (!reset_n) begin
      run[k] = 1'b0;
      fcb[k] = 0;
    end else if (!enable) begin
      if (run[k]) fcb[k] = cur_fc(k);
      run[k] = 1'b0;
    end else if (!run[k]) begin
      run[k] = 1'b1;
      t[k] = 0;
    end else begin
      t[k]++;
    end
  endtask

  task automatic track_run(input int id, input string tag, input logic sig, input logic act, input int want);
    if (sig === act) begin
      rl_len[id]++;
    end else begin
      if (rl_len[id] > 0) check_val(tag, 64'(rl_len[id]), 64'(want));
      rl_len[id] = 0;
    end
  endtask

  task automatic track_period(input int id, input string tag, input logic ev, input int want);
    if (ev === 1'b1) begin
      if (pd_last[id] >= 0) check_val(tag, 64'(cyc - pd_last[id]), 64'(want));
      pd_last[id] = cyc;
    end
  endtask

  task automatic do_measure();
    track_run(0, "d0_hs_width", d0_hsync, 1'b0, 3);
    if (d0_hs_prev === 1'b1 && d0_hsync === 1'b0) check_val("d0_hs_lead_x", 64'(d0_x_prev), 64'd10);
    track_period(0, "d0_line_period", d0_line_start, 15);
    track_period(1, "d0_frame_period", d0_frame_start, 120);
    if (d0_frame_start === 1'b1 && fs0_first < 0) fs0_first = cyc;
    if (fs0_first >= 0 && cyc - fs0_first == 360) check_val("d0_fc_at_360", 64'(d0_frame_count), 64'd3);
    if (fs0_first >= 0 && cyc - fs0_first == 480) check_val("d0_fc_wrap_480", 64'(d0_frame_count), 64'd0);
    track_run(1, "d1_hs_width", d1_hsync, 1'b1, 9);
    track_run(2, "d1_vs_width", d1_vsync, 1'b1, 90);
    track_period(2, "d1_pix_period", d1_pix_en, 3);
    track_run(3, "d2_hs_width", d2_hsync, 1'b0, 96);
    track_period(3, "d2_hs_period", d2_hs_prev === 1'b1 && d2_hsync === 1'b0, 800);
    d0_hs_prev = d0_hsync;
    d0_x_prev  = d0_x;
    d2_hs_prev = d2_hsync;
  endtask

  // One clk: advance the model, compare all instances, then drive fresh colours
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < ND; k++) model_step(k);
    cyc++;
    #2;
    check_val("d0_out", obs(0), exp_pack(0));
    check_val("d1_out", obs(1), exp_pack(1));
    check_val("d2_out", obs(2), exp_pack(2));
    if (measure) do_measure();
    d0_rgb_in = 3'($urandom);
    d1_rgb_in = 5'($urandom);
    d2_rgb_in = 3'($urandom);
    if (pix_exp(0)) cap[0] = int'(d0_rgb_in);
    if (pix_exp(1)) cap[1] = int'(d1_rgb_in);
    if (pix_exp(2)) cap[2] = int'(d2_rgb_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fc_hold;
    bit found;
    reset_n = 1'b0;
    enable = 1'b0;
    d0_rgb_in = '0;
    d1_rgb_in = '0;
    d2_rgb_in = '0;
    model_reset_all();
    for (int k = 0; k < ND; k++) cap[k] = 0;
    for (int i = 0; i < 4; i++) begin
      rl_len[i] = 0;
      pd_last[i] = -1;
    end

    $display("txn reset_hold");
    cycle();
    cycle();
    check_val("d0_reset_state", obs(0), {16'd0, 16'd0, 8'd0, 8'd0, 8'd7, 8'b00011011});
    check_val("d1_reset_state", obs(1), {16'd0, 16'd0, 8'd0, 8'd0, 8'd31, 8'b00000011});

    $display("txn clean_run cycles=1600");
    d0_hs_prev = 1'b1;
    d2_hs_prev = 1'b1;
    d0_x_prev = '0;
    reset_n = 1'b1;
    enable = 1'b1;
    measure = 1'b1;
    for (int i = 0; i < 1600; i++) cycle();
    measure = 1'b0;

    $display("txn async_reset_at_x5_y2");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (run[0] && (t[0] % 120) == 35) found = 1'b1;
      else cycle();
    end
    if (!found) check_val("d0_seek_x5y2", 64'd0, 64'd1);
    check_val("d0_pre_rst_xy", 64'({d0_x, d0_y}), 64'({4'd5, 3'd2}));
    reset_n = 1'b0;
    model_reset_all();
    #1;
    check_val("d0_async_rst", obs(0), {16'd0, 16'd0, 8'd0, 8'd0, 8'd7, 8'b00011011});
    check_val("d1_async_rst", obs(1), {16'd0, 16'd0, 8'd0, 8'd0, 8'd31, 8'b00000011});
    #1;
    reset_n = 1'b1;
    cycle();
    check_val("d0_fs_after_rst", 64'(d0_frame_start), 64'd1);
    cycle();
    cycle();
    check_val("d1_first_fs", 64'(d1_frame_start), 64'd1);

    $display("txn enable_drop_mid_frame");
    for (int i = 0; i < 50; i++) cycle();
    fc_hold = cur_fc(0);
    enable = 1'b0;
    cycle();
    check_val("d0_oeb_on_disable", 64'({d0_oeb_hs, d0_oeb_vs, d0_oeb_rgb}), 64'h1f);
    check_val("d0_fc_hold", 64'(d0_frame_count), 64'(fc_hold));
    cycle();
    enable = 1'b1;
    cycle();
    check_val("d0_oeb_on_enable", 64'({d0_oeb_hs, d0_oeb_vs, d0_oeb_rgb}), 64'h00);

    $display("txn random_run cycles=3000");
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        model_reset_all();
      end
      if (!enable) enable = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 249) == 0) enable = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA sync and pixel pipeline; successor to the fixed-mode demo video output.
- Generates hsync/vsync, pixel coordinates and frame/line strobes.
- Blanks and registers an RGB_W-bit colour input, and drives per-pin output enables for the Caravel GPIO.
- Sits between a pixel-colour generator (combinational on x/y) and the io_out/io_oeb pins of the user wrapper.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
RGB_W, 3, colour bits (1..24)
CLK_DIV, 1, clk cycles per pixel (>=1)
FRAME_W, 8, frame counter width
Derived localparams: H_TOTAL = sum of the H_* terms; V_TOTAL likewise; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run; low = hold idle and tristate pins
rgb_in  in  RGB_W  colour for current (x,y), sampled on pix_en
x  out  XW  current horizontal counter
y  out  YW  current vertical counter
pix_en  out  1  one-clk pixel tick
line_start  out  1  pix_en at x==0
frame_start  out  1  pix_en at x==0 and y==0
frame_count  out  FRAME_W  completed frames, wraps
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
rgb  out  RGB_W  registered, blanked colour
display_on  out  1  registered active-area flag, aligned with rgb
oeb_hs  out  1  output enable bar for hsync
oeb_vs  out  1  output enable bar for vsync
oeb_rgb  out  RGB_W  output enable bar per colour bit

Behaviour:
- Reset values (async, on reset_n low):
  - x = 0, y = 0; divider = 0.
  - pix_en, line_start, frame_start, display_on = 0; rgb = 0; frame_count = 0.
  - hsync = ~HS_POL; vsync = ~VS_POL.
  - oeb_* all 1.
- Reset release is synchronous to clk (no glitch on the outputs).
- Divider: counts 0..CLK_DIV-1; pix_en = 1 when the divider equals CLK_DIV-1. With CLK_DIV = 1, pix_en is constantly 1 while enabled.
- On pix_en:
  - x increments; when x == H_TOTAL-1, x wraps to 0 and y increments.
  - When y == V_TOTAL-1 and x wraps, y wraps to 0 and frame_count increments (mod 2^FRAME_W).
- Registered outputs update on pix_en, computed from the pre-increment x/y. Latency is one pixel relative to x/y:
  - hsync = HS_POL when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC, else ~VS_POL.
  - active = (x < H_ACTIVE) && (y < V_ACTIVE); display_on = active; rgb = active ? rgb_in : 0.
- line_start and frame_start are combinational: pix_en qualified by the counter values.
- Enable low (checked every clk, takes priority over the pixel tick):
  - Next clk: counters, divider and strobes go to 0; rgb = 0; syncs inactive; oeb_* = 1.
  - frame_count holds.
- Enable rising: the first pix_en occurs CLK_DIV clks later at x = 0, y = 0, so frame_start fires. oeb_* go 0 on the first enabled clk.
- Partial frame: no frame_count increment when enable drops or reset occurs mid-frame.
- Reset mid-frame: everything returns immediately to the reset values. Restart is as for enable rising, provided enable = 1.
- Illegal parameters (CLK_DIV < 1, any timing term 0): elaboration error via generate-time check.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants;
  - a second preset set (800x600@60);
  - a function computing the sync window predicate.
- Sub-module vga_axis_counter holds one axis. It is parametrised by ACTIVE/FRONT/SYNC/BACK/POL, with ports:
  - inputs: clk, reset_n, clr, step;
  - outputs: count, wrap, in_active, sync_level.
- vga_axis_counter is instantiated twice: h steps on pix_en; v steps on h.wrap.

Test Plan:
- Small params (H 8/2/3/2 = 15 pixels; V 4/1/2/1 = 8 lines; CLK_DIV = 1; HS_POL = 0):
  - hsync low for exactly 3 clks, starting 1 clk after x == 10;
  - line period 15 clks; frame period 120 clks; frame_count = 3 after 360 clks from the first frame_start.
- Same params, rgb_in = x[2:0]:
  - rgb equals the previous x while display_on = 1;
  - rgb = 0 for all x >= 8 or y >= 4.
- CLK_DIV = 3, HS_POL = 1, VS_POL = 1:
  - pix_en asserts every 3rd clk;
  - hsync high for 9 clks per line;
  - vsync high for 2*15*3 = 90 clks per frame.
- Reset/enable:
  - reset_n low at x = 5, y = 2: all outputs at reset values asynchronously;
  - release with enable = 1: first frame_start exactly 1 clk later (CLK_DIV = 1);
  - enable low mid-frame: oeb_* = 1 next clk and frame_count unchanged.
- Default 640x480: hsync period 800 clks; vsync low for 1600 clks per 420000-clk frame.
- frame_count wrap: FRAME_W = 2 wraps 3 -> 0 on the 4th completed frame.
